// File: rtl/eth_tx_framer_if.sv
// rtl/eth_tx_framer_if.sv - upstream byte stream in, GMII TX and stats out
interface eth_tx_framer_if;
    logic [7:0]  i_data;
    logic        i_tx_en;
    logic [7:0]  o_data;
    logic        o_tx_en;
    logic        o_ready;
    logic        o_trunc;
    logic [15:0] o_frame_cnt;
    logic [15:0] o_drop_cnt;

    modport master (
        output i_data, i_tx_en,
        input  o_data, o_tx_en, o_ready, o_trunc, o_frame_cnt, o_drop_cnt
    );

    modport slave (
        input  i_data, i_tx_en,
        output o_data, o_tx_en, o_ready, o_trunc, o_frame_cnt, o_drop_cnt
    );
endinterface

// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - GMII TX framer: preamble/SFD, zero pad, CRC32 FCS, IFG; stats counters under ETH_TX_FRAMER_STATS_EN
module eth_tx_framer #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int IFG_LEN = 12
) (
    input  logic            clk,
    input  logic            rst,
    eth_tx_framer_if.slave  txif
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_FCS  = 3'd5;
    localparam logic [2:0] S_IFG  = 3'd6;

    localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN - 1);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_LEN);

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    logic [2:0]  state, nxt_state;
    logic [7:0]  cnt, nxt_cnt;
    logic [10:0] byte_cnt, nxt_byte_cnt;
    logic [31:0] crc, nxt_crc;
    logic [7:0]  nxt_data;
    logic        nxt_tx_en, nxt_trunc, finish;
    logic        prev_tx_en;
    logic        start;
    logic [7:0]  dl_data [9];
    logic [8:0]  dl_valid;
    logic [31:0] fcs_word;
    logic [7:0]  fcs_sel;

    // prev_tx_en resets high so a frame already in flight at reset release is never picked up mid-way
    assign start         = txif.i_tx_en & ~prev_tx_en;
    assign txif.o_ready  = (state == S_IDLE);
    assign fcs_word      = ~crc;

    // FCS byte for the current position, least significant byte first
    always_comb begin
        fcs_sel = fcs_word[7:0];
        case (cnt[1:0])
            2'd1:    fcs_sel = fcs_word[15:8];
            2'd2:    fcs_sel = fcs_word[23:16];
            2'd3:    fcs_sel = fcs_word[31:24];
            default: fcs_sel = fcs_word[7:0];
        endcase
    end

    // Next-state and next-output decode; outputs are registered so each state drives the byte of the following edge
    always_comb begin
        nxt_state    = state;
        nxt_cnt      = cnt;
        nxt_byte_cnt = byte_cnt;
        nxt_crc      = crc;
        nxt_data     = 8'h00;
        nxt_tx_en    = 1'b0;
        nxt_trunc    = 1'b0;
        finish       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt_state    = S_PRE;
                    nxt_cnt      = 8'd0;
                    nxt_byte_cnt = 11'd0;
                    nxt_crc      = 32'hFFFF_FFFF;
                end
            end
            S_PRE: begin
                nxt_data  = 8'h55;
                nxt_tx_en = 1'b1;
                if (cnt == 8'd6) nxt_state = S_SFD;
                else             nxt_cnt   = cnt + 8'd1;
            end
            S_SFD: begin
                nxt_data  = 8'hD5;
                nxt_tx_en = 1'b1;
                nxt_state = S_DATA;
            end
            S_DATA: begin
                if (dl_valid[8] && byte_cnt == MAX_CNT) begin
                    // Oversize: close the frame now; the input residue drains while we send FCS/IFG
                    nxt_trunc = 1'b1;
                    nxt_data  = fcs_word[7:0];
                    nxt_tx_en = 1'b1;
                    nxt_cnt   = 8'd1;
                    nxt_state = S_FCS;
                end else if (dl_valid[8]) begin
                    nxt_data     = dl_data[8];
                    nxt_tx_en    = 1'b1;
                    nxt_crc      = crc_byte(crc, dl_data[8]);
                    nxt_byte_cnt = byte_cnt + 11'd1;
                end else begin
                    finish = 1'b1;
                end
            end
            S_PAD: finish = 1'b1;
            S_FCS: begin
                nxt_data  = fcs_sel;
                nxt_tx_en = 1'b1;
                if (cnt == 8'd3) begin
                    nxt_state = S_IFG;
                    nxt_cnt   = 8'd0;
                end else begin
                    nxt_cnt = cnt + 8'd1;
                end
            end
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = 8'd0;
                end else begin
                    nxt_cnt = cnt + 8'd1;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
        // End of payload: pad up to the minimum, otherwise go straight into the first FCS byte with no gap
        if (finish) begin
            nxt_tx_en = 1'b1;
            if (byte_cnt < MIN_CNT) begin
                nxt_data     = 8'h00;
                nxt_crc      = crc_byte(crc, 8'h00);
                nxt_byte_cnt = byte_cnt + 11'd1;
                nxt_state    = S_PAD;
            end else begin
                nxt_data  = fcs_word[7:0];
                nxt_cnt   = 8'd1;
                nxt_state = S_FCS;
            end
        end
    end

    // State, CRC, output registers and the 9-stage input delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= 8'd0;
            byte_cnt      <= 11'd0;
            crc           <= 32'hFFFF_FFFF;
            prev_tx_en    <= 1'b1;
            dl_valid      <= 9'd0;
            txif.o_data   <= 8'h00;
            txif.o_tx_en  <= 1'b0;
            txif.o_trunc  <= 1'b0;
            for (int i = 0; i < 9; i++) dl_data[i] <= 8'h00;
        end else begin
            state         <= nxt_state;
            cnt           <= nxt_cnt;
            byte_cnt      <= nxt_byte_cnt;
            crc           <= nxt_crc;
            prev_tx_en    <= txif.i_tx_en;
            dl_valid      <= {dl_valid[7:0], txif.i_tx_en};
            txif.o_data   <= nxt_data;
            txif.o_tx_en  <= nxt_tx_en;
            txif.o_trunc  <= nxt_trunc;
            dl_data[0]    <= txif.i_data;
            for (int i = 1; i < 9; i++) dl_data[i] <= dl_data[i-1];
        end
    end

`ifdef ETH_TX_FRAMER_STATS_EN
    logic [15:0] frame_cnt, drop_cnt;
    logic        frame_done, drop;
    assign frame_done = (state == S_FCS) && (cnt == 8'd3);
    assign drop       = start && (state != S_IDLE);

    // Sent/dropped frame statistics, free-running 16-bit wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
            drop_cnt  <= 16'd0;
        end else begin
            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
            if (drop)       drop_cnt  <= drop_cnt + 16'd1;
        end
    end
    assign txif.o_frame_cnt = frame_cnt;
    assign txif.o_drop_cnt  = drop_cnt;
`else
    assign txif.o_frame_cnt = 16'd0;
    assign txif.o_drop_cnt  = 16'd0;
`endif
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - self-checking bench for eth_tx_framer against a frame-level reference model
module tb_eth_tx_framer;
`ifdef ETH_TX_FRAMER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    eth_tx_framer_if txif();
    eth_tx_framer dut (.clk(clk), .rst(rst), .txif(txif));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] din[$];
    logic [7:0] dexp[$];
    logic [7:0] cbuf[$];
    logic [7:0] cap_bytes[$];
    int cap_off[$], cap_len[$], cap_first[$], cap_ifg[$];
    int trunc_seen = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: splits the GMII stream into frames and measures the gap until ready
    initial begin
        int cur_len, cur_first, last_end;
        bit in_tx, wait_rdy;
        cur_len = 0; cur_first = 0; last_end = 0; in_tx = 0; wait_rdy = 0;
        forever begin
            @(negedge clk);
            if (txif.o_trunc === 1'b1) trunc_seen++;
            if (txif.o_tx_en === 1'b1) begin
                if (!in_tx) begin
                    in_tx = 1; cur_first = cyc; cur_len = 0;
                    cap_off.push_back(cap_bytes.size());
                    if (wait_rdy) begin cap_ifg.push_back(-1); wait_rdy = 0; end
                end
                cap_bytes.push_back(txif.o_data);
                cur_len++;
                last_end = cyc;
            end else begin
                if (in_tx) begin
                    in_tx = 0;
                    cap_len.push_back(cur_len);
                    cap_first.push_back(cur_first);
                    wait_rdy = 1;
                end
                if (wait_rdy && txif.o_ready === 1'b1) begin
                    cap_ifg.push_back(cyc - last_end);
                    wait_rdy = 0;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [31:0] crc_cbuf();
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (cbuf[i]) begin
            for (int b = 0; b < 8; b++) begin
                logic fb;
                fb = c[0] ^ cbuf[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    // Reference: preamble, SFD, payload cut at 1514, zero pad to 60, then ~CRC LSB first
    function automatic void build_exp();
        int n = (din.size() > 1514) ? 1514 : din.size();
        logic [31:0] fcs;
        dexp.delete();
        cbuf.delete();
        for (int i = 0; i < n; i++) cbuf.push_back(din[i]);
        while (cbuf.size() < 60) cbuf.push_back(8'h00);
        fcs = ~crc_cbuf();
        repeat (7) dexp.push_back(8'h55);
        dexp.push_back(8'hD5);
        foreach (cbuf[i]) dexp.push_back(cbuf[i]);
        for (int b = 0; b < 4; b++) dexp.push_back(fcs[8*b +: 8]);
    endfunction

    function automatic int frame_errs(input int idx);
        int e = 0;
        if (cap_len[idx] != dexp.size()) e++;
        for (int j = 0; j < cap_len[idx] && j < dexp.size(); j++)
            if (cap_bytes[cap_off[idx] + j] !== dexp[j]) e++;
        return e;
    endfunction

    function automatic logic [31:0] cap_residue(input int idx);
        cbuf.delete();
        for (int j = 8; j < cap_len[idx]; j++) cbuf.push_back(cap_bytes[cap_off[idx] + j]);
        return crc_cbuf();
    endfunction

    task automatic fill(input int len);
        din.delete();
        repeat (len) din.push_back(8'($urandom));
    endtask

    task automatic goto_edge(input int e);
        while (cyc < e) begin @(posedge clk); #1; end
    endtask

    // Drives din as one frame; start is sampled at edge k; leaves one low cycle behind it
    task automatic drive(output int k);
        k = cyc + 1;
        foreach (din[i]) begin
            txif.i_data = din[i]; txif.i_tx_en = 1'b1;
            @(posedge clk); #1;
        end
        txif.i_tx_en = 1'b0; txif.i_data = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic wait_caps(input int n);
        int t = 0;
        while (cap_ifg.size() < n && t < 4000) begin @(negedge clk); t++; end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; txif.i_tx_en = 1'b1; txif.i_data = 8'($urandom);
        repeat (3) begin @(posedge clk); #1; end
        n_tests++; if (txif.o_tx_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en got %b want 0", txif.o_tx_en); end
        n_tests++; if (txif.o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", txif.o_data); end
        n_tests++; if (txif.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", txif.o_ready); end
        n_tests++; if (txif.o_trunc !== 1'b0) begin n_fail++; $display("FAIL reset_trunc got %b want 0", txif.o_trunc); end
        n_tests++; if (txif.o_frame_cnt !== 16'd0 || txif.o_drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", txif.o_frame_cnt, txif.o_drop_cnt); end
        rst = 1'b0;
        repeat (20) begin txif.i_data = 8'($urandom); @(posedge clk); #1; end
        txif.i_tx_en = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        n_tests++; if (cap_off.size() != 0) begin n_fail++; $display("FAIL reset_inflight_ignored got %0d frames want 0", cap_off.size()); end
    endtask

    task automatic test_arp();
        int k, n0;
        logic [15:0] fc0;
        int t0;
        fill(42); build_exp();
        n0 = cap_ifg.size(); fc0 = txif.o_frame_cnt; t0 = trunc_seen;
        drive(k);
        wait_caps(n0 + 1);
        n_tests++;
        if (cap_ifg.size() < n0 + 1) begin n_fail++; $display("FAIL arp_frame_seen got %0d want %0d", cap_ifg.size(), n0 + 1); end
        else begin
            n_tests++; if (cap_len[n0] != 72) begin n_fail++; $display("FAIL arp_tx_en_len got %0d want 72", cap_len[n0]); end
            n_tests++; if (frame_errs(n0) != 0) begin n_fail++; $display("FAIL arp_bytes got %0d bad want 0", frame_errs(n0)); end
            n_tests++; if (cap_first[n0] != k + 1) begin n_fail++; $display("FAIL arp_preamble_start got %0d want %0d", cap_first[n0], k + 1); end
            n_tests++; if (cap_residue(n0) !== 32'hDEBB20E3) begin n_fail++; $display("FAIL arp_residue got %h want debb20e3", cap_residue(n0)); end
            n_tests++; if (cap_ifg[n0] != 12) begin n_fail++; $display("FAIL arp_ifg got %0d want 12", cap_ifg[n0]); end
        end
        n_tests++; if (trunc_seen != t0) begin n_fail++; $display("FAIL arp_no_trunc got %0d want %0d", trunc_seen, t0); end
        n_tests++; if (16'(txif.o_frame_cnt - fc0) !== 16'(STATS)) begin n_fail++; $display("FAIL arp_frame_cnt got %0d want %0d", txif.o_frame_cnt - fc0, STATS); end
    endtask

    task automatic test_lengths();
        int lens[7] = '{1, 59, 60, 61, 100, 1514, 0};
        int k, n0, t0;
        lens[6] = $urandom_range(2, 300);
        foreach (lens[r]) begin
            fill(lens[r]); build_exp();
            n0 = cap_ifg.size(); t0 = trunc_seen;
            drive(k);
            wait_caps(n0 + 1);
            n_tests++;
            if (cap_ifg.size() < n0 + 1) begin n_fail++; $display("FAIL len%0d_frame_seen got %0d want %0d", lens[r], cap_ifg.size(), n0 + 1); end
            else begin
                n_tests++; if (frame_errs(n0) != 0) begin n_fail++; $display("FAIL len%0d_bytes got %0d bad (len %0d) want 0 (len %0d)", lens[r], frame_errs(n0), cap_len[n0], dexp.size()); end
                n_tests++; if (cap_first[n0] != k + 1) begin n_fail++; $display("FAIL len%0d_latency got %0d want %0d", lens[r], cap_first[n0], k + 1); end
                n_tests++; if (cap_ifg[n0] != 12) begin n_fail++; $display("FAIL len%0d_ifg got %0d want 12", lens[r], cap_ifg[n0]); end
            end
            n_tests++; if (trunc_seen != t0) begin n_fail++; $display("FAIL len%0d_no_trunc got %0d want %0d", lens[r], trunc_seen, t0); end
            goto_edge(cyc + $urandom_range(1, 8));
        end
    endtask

    task automatic test_drop();
        int k, kb, kc, n0;
        logic [15:0] fc0, dc0;
        fill(30); build_exp();
        n0 = cap_ifg.size(); fc0 = txif.o_frame_cnt; dc0 = txif.o_drop_cnt;
        drive(k);
        goto_edge(k + 49);
        fill(5); drive(kb);
        goto_edge(k + 83);
        fill(10); drive(kc);
        wait_caps(n0 + 1);
        repeat (120) begin @(posedge clk); #1; end
        n_tests++; if (kc != k + 84) begin n_fail++; $display("FAIL drop_ifg_start_edge got %0d want %0d", kc, k + 84); end
        n_tests++; if (cap_off.size() != n0 + 1) begin n_fail++; $display("FAIL drop_frames_out got %0d want %0d", cap_off.size(), n0 + 1); end
        else begin
            n_tests++; if (frame_errs(n0) != 0) begin n_fail++; $display("FAIL drop_first_bytes got %0d bad want 0", frame_errs(n0)); end
        end
        n_tests++; if (16'(txif.o_drop_cnt - dc0) !== 16'(2 * STATS)) begin n_fail++; $display("FAIL drop_cnt got %0d want %0d", txif.o_drop_cnt - dc0, 2 * STATS); end
        n_tests++; if (16'(txif.o_frame_cnt - fc0) !== 16'(STATS)) begin n_fail++; $display("FAIL drop_frame_cnt got %0d want %0d", txif.o_frame_cnt - fc0, STATS); end
    endtask

    task automatic test_trunc();
        int k, n0, t0;
        logic [15:0] dc0;
        fill(1600); build_exp();
        n0 = cap_ifg.size(); t0 = trunc_seen;
        drive(k);
        wait_caps(n0 + 1);
        n_tests++;
        if (cap_ifg.size() < n0 + 1) begin n_fail++; $display("FAIL trunc_frame_seen got %0d want %0d", cap_ifg.size(), n0 + 1); end
        else begin
            n_tests++; if (cap_len[n0] != 1526) begin n_fail++; $display("FAIL trunc_len got %0d want 1526", cap_len[n0]); end
            n_tests++; if (frame_errs(n0) != 0) begin n_fail++; $display("FAIL trunc_bytes got %0d bad want 0", frame_errs(n0)); end
            n_tests++; if (cap_residue(n0) !== 32'hDEBB20E3) begin n_fail++; $display("FAIL trunc_residue got %h want debb20e3", cap_residue(n0)); end
        end
        n_tests++; if (trunc_seen != t0 + 1) begin n_fail++; $display("FAIL trunc_pulses got %0d want %0d", trunc_seen - t0, 1); end
        fill(20); build_exp();
        n0 = cap_ifg.size(); dc0 = txif.o_drop_cnt;
        drive(k);
        wait_caps(n0 + 1);
        n_tests++;
        if (cap_ifg.size() < n0 + 1) begin n_fail++; $display("FAIL after_trunc_seen got %0d want %0d", cap_ifg.size(), n0 + 1); end
        else begin
            n_tests++; if (frame_errs(n0) != 0) begin n_fail++; $display("FAIL after_trunc_bytes got %0d bad want 0", frame_errs(n0)); end
        end
        n_tests++; if (txif.o_drop_cnt !== dc0) begin n_fail++; $display("FAIL after_trunc_drop got %0d want %0d", txif.o_drop_cnt, dc0); end
    endtask

    task automatic test_reset_mid();
        int k, n0, n1;
        fill(80);
        n0 = cap_off.size();
        k = cyc + 1;
        foreach (din[i]) begin
            txif.i_data = din[i]; txif.i_tx_en = 1'b1;
            if (i == 30) begin
                rst = 1'b1;
                #1;
                n_tests++; if (txif.o_tx_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_en got %b want 0", txif.o_tx_en); end
                n_tests++; if (txif.o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_frame_cnt got %0d want 0", txif.o_frame_cnt); end
            end
            if (i == 33) rst = 1'b0;
            @(posedge clk); #1;
        end
        txif.i_tx_en = 1'b0;
        repeat (120) begin @(posedge clk); #1; end
        n_tests++; if (cap_off.size() != n0 + 1) begin n_fail++; $display("FAIL rstmid_frames got %0d want %0d", cap_off.size(), n0 + 1); end
        else begin
            n_tests++; if (cap_len[n0] != 28) begin n_fail++; $display("FAIL rstmid_partial_len got %0d want 28", cap_len[n0]); end
        end
        fill(40); build_exp();
        n1 = cap_ifg.size();
        drive(k);
        wait_caps(n1 + 1);
        n_tests++;
        if (cap_ifg.size() < n1 + 1) begin n_fail++; $display("FAIL rstmid_next_seen got %0d want %0d", cap_ifg.size(), n1 + 1); end
        else begin
            n_tests++; if (frame_errs(n1) != 0) begin n_fail++; $display("FAIL rstmid_next_bytes got %0d bad want 0", frame_errs(n1)); end
        end
    endtask

    task automatic test_back_to_back();
        int ka, kb, n0;
        logic [7:0] exp_a[$];
        logic [15:0] dc0, fc0;
        fill(60); build_exp(); exp_a = dexp;
        n0 = cap_ifg.size(); dc0 = txif.o_drop_cnt; fc0 = txif.o_frame_cnt;
        drive(ka);
        goto_edge(ka + 84);
        fill(60);
        drive(kb);
        build_exp();
        wait_caps(n0 + 2);
        n_tests++;
        if (cap_ifg.size() < n0 + 2) begin n_fail++; $display("FAIL b2b_frames got %0d want %0d", cap_ifg.size(), n0 + 2); end
        else begin
            n_tests++; if (frame_errs(n0 + 1) != 0) begin n_fail++; $display("FAIL b2b_second_bytes got %0d bad want 0", frame_errs(n0 + 1)); end
            n_tests++; if (cap_first[n0 + 1] != ka + 86) begin n_fail++; $display("FAIL b2b_second_start got %0d want %0d", cap_first[n0 + 1], ka + 86); end
            n_tests++; if (cap_ifg[n0] != 12) begin n_fail++; $display("FAIL b2b_ifg got %0d want 12", cap_ifg[n0]); end
            dexp = exp_a;
            n_tests++; if (frame_errs(n0) != 0) begin n_fail++; $display("FAIL b2b_first_bytes got %0d bad want 0", frame_errs(n0)); end
        end
        n_tests++; if (txif.o_drop_cnt !== dc0) begin n_fail++; $display("FAIL b2b_drop_cnt got %0d want %0d", txif.o_drop_cnt, dc0); end
        n_tests++; if (16'(txif.o_frame_cnt - fc0) !== 16'(2 * STATS)) begin n_fail++; $display("FAIL b2b_frame_cnt got %0d want %0d", txif.o_frame_cnt - fc0, 2 * STATS); end
    endtask

    initial begin
        txif.i_data  = 8'h00;
        txif.i_tx_en = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_arp();
        test_lengths();
        test_drop();
        test_trunc();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
